// File: rtl/input_port_buffer.sv
// Per-port receive FIFO: captures upstream flits, attaches the XY route label at write time.
// Optional flit statistics counter enabled by defining IPB_STATS_EN.
module input_port_buffer #(
  parameter int          DEPTH     = 4,
  parameter int          WIDTH     = 2,
  parameter int          DATASIZE  = 30,
  parameter logic [3:0]  router_ID = 4'd6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                valid_in,
  output logic                full,
  output logic [DATASIZE-1:0] data_out,
  output logic [4:0]          label,
  output logic                valid_out,
  input  logic                ready,
  output logic                err_overflow
`ifdef IPB_STATS_EN
  ,
  output logic [15:0]         flit_count
`endif
);

  localparam logic [WIDTH:0] FULL_CNT = (WIDTH+1)'(DEPTH);

  logic [DATASIZE+4:0] mem [DEPTH];
  logic [WIDTH-1:0]    wptr;
  logic [WIDTH-1:0]    rptr;
  logic [WIDTH:0]      count;
  logic [4:0]          route;
  logic [DATASIZE+4:0] head;
  logic                wr_en;
  logic                rd_en;

  // Handshake: a flit is taken at any edge with valid_in=1 and full=0; the head is
  // consumed at any edge with ready=1 and valid_out=1. full/valid_out come from
  // registered count only, so neither has a combinational path from valid_in/ready.
  assign full      = (count == FULL_CNT);
  assign valid_out = (count != '0);
  assign wr_en     = valid_in & ~full;
  assign rd_en     = ready & valid_out;

  // X dimension is resolved before Y.
  always_comb begin
    route = 5'b00001;
    if (data_in[1:0] > router_ID[1:0])
      route = 5'b00100;
    else if (data_in[1:0] < router_ID[1:0])
      route = 5'b01000;
    else if (data_in[3:2] > router_ID[3:2])
      route = 5'b00010;
    else if (data_in[3:2] < router_ID[3:2])
      route = 5'b10000;
  end

  // Entry storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!rst_n && wr_en)
      mem[wptr] <= {route, data_in};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (wr_en)
        wptr <= wptr + WIDTH'(1);
      if (rd_en)
        rptr <= rptr + WIDTH'(1);
      if (wr_en && !rd_en)
        count <= count + (WIDTH+1)'(1);
      else if (rd_en && !wr_en)
        count <= count - (WIDTH+1)'(1);
      if (valid_in && full)
        err_overflow <= 1'b1;
    end
  end

  assign head     = mem[rptr];
  assign data_out = head[DATASIZE-1:0] & {DATASIZE{valid_out}};
  assign label    = head[DATASIZE+4:DATASIZE] & {5{valid_out}};

`ifdef IPB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst_n)
      flit_count <= '0;
    else if (wr_en && flit_count != 16'hFFFF)
      flit_count <= flit_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_input_port_buffer.sv
// Bench for input_port_buffer: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations and a randomized phase.
module tb_input_port_buffer;

  localparam int         DEPTH    = 4;
  localparam int         WIDTH    = 2;
  localparam int         DATASIZE = 30;
  localparam logic [3:0] RID      = 4'd6;

  logic                clk;
  logic                rst_n;
  logic [DATASIZE-1:0] data_in;
  logic                valid_in;
  logic                full;
  logic [DATASIZE-1:0] data_out;
  logic [4:0]          label;
  logic                valid_out;
  logic                ready;
  logic                err_overflow;
`ifdef IPB_STATS_EN
  logic [15:0]         flit_count;
`endif

  input_port_buffer #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DATASIZE), .router_ID(RID)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .valid_in(valid_in),
    .full(full),
    .data_out(data_out),
    .label(label),
    .valid_out(valid_out),
    .ready(ready),
    .err_overflow(err_overflow)
`ifdef IPB_STATS_EN
    ,
    .flit_count(flit_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a queue of {label, flit} plus sticky error and counter
  logic [DATASIZE+4:0] exp_q[$];
  bit                  m_err;
  int                  m_cnt;

  function automatic logic [4:0] route_of(input logic [3:0] d);
    int dx, dy, mx, my;
    dx = d % 4;  dy = d / 4;
    mx = RID % 4; my = RID / 4;
    if (dx > mx) return 5'b00100;
    if (dx < mx) return 5'b01000;
    if (dy > my) return 5'b00010;
    if (dy < my) return 5'b10000;
    return 5'b00001;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      exp_q.delete();
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      bit was_full;
      was_full = (exp_q.size() == DEPTH);
      if (ready && exp_q.size() != 0)
        void'(exp_q.pop_front());
      if (valid_in && !was_full) begin
        exp_q.push_back({route_of(data_in[3:0]), data_in});
        if (m_cnt < 65535) m_cnt++;
      end
      if (valid_in && was_full)
        m_err = 1'b1;
    end
  end

  // per-cycle compare on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [DATASIZE+4:0] h;
      h = (exp_q.size() != 0) ? exp_q[0] : '0;
      check("full",      32'(full),      32'(exp_q.size() == DEPTH));
      check("valid_out", 32'(valid_out), 32'(exp_q.size() != 0));
      check("data_out",  32'(data_out),  32'(h[DATASIZE-1:0]));
      check("label",     32'(label),     32'(h[DATASIZE+4:DATASIZE]));
      check("err",       32'(err_overflow), 32'(m_err));
`ifdef IPB_STATS_EN
      check("flit_count", 32'(flit_count), 32'(m_cnt));
`endif
    end
  end

  // driver tasks: drive just after the edge, return 1 time unit after the next edge
  task automatic cyc(input bit v, input logic [DATASIZE-1:0] d, input bit r);
    valid_in = v; data_in = d; ready = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1; valid_in = 1'b0; ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
  endtask

  logic [DATASIZE-1:0] f1;
  logic [DATASIZE-1:0] last;
  logic [3:0]          dests [4];

  initial begin
    rst_n = 1'b1; valid_in = 1'b0; ready = 1'b0; data_in = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    chk_en = 1'b1;
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_full",      32'(full),      32'd0);

    // three local-destination flits
    cyc(1'b1, {26'h1, 4'h6}, 1'b0);
    check("local_label", 32'(label), 32'b00001);
    check("local_valid", 32'(valid_out), 32'd1);
    cyc(1'b1, {26'h2, 4'h6}, 1'b0);
    cyc(1'b1, {26'h3, 4'h6}, 1'b0);
    check("three_not_full", 32'(full), 32'd0);

    // fill with E/W/S/N destinations, overflow, then drain
    do_reset();
    dests[0] = 4'h7; dests[1] = 4'h5; dests[2] = 4'hA; dests[3] = 4'h2;
    f1 = {26'h2AB, 4'h7};
    cyc(1'b1, f1, 1'b0);
    for (int i = 1; i < 4; i++) cyc(1'b1, {26'(i + 16'h100), dests[i]}, 1'b0);
    check("fill_full", 32'(full), 32'd1);
    cyc(1'b1, {26'h3FF, 4'h1}, 1'b0);
    check("ovf_err",   32'(err_overflow), 32'd1);
    check("ovf_head",  32'(data_out), 32'(f1));
    check("head_E",    32'(label), 32'b00100);
    cyc(1'b1, {26'h3FE, 4'h1}, 1'b1);     // pop while full: write still refused
    check("pop_unfull", 32'(full), 32'd0);
    check("head_W",    32'(label), 32'b01000);
    cyc(1'b0, '0, 1'b1);
    check("head_S",    32'(label), 32'b00010);
    cyc(1'b0, '0, 1'b1);
    check("head_N",    32'(label), 32'b10000);
    cyc(1'b0, '0, 1'b1);
    check("drained_valid", 32'(valid_out), 32'd0);
    check("drained_data",  32'(data_out), 32'd0);
    cyc(1'b0, '0, 1'b1);                  // ready while empty is ignored

    // streaming: one in, one out per cycle across pointer wrap
    for (int i = 0; i < 20; i++) begin
      last = {DATASIZE{1'b0}} | DATASIZE'($urandom);
      cyc(1'b1, last, 1'b1);
      check("stream_head", 32'(data_out), 32'(last));
    end
    cyc(1'b0, '0, 1'b1);

    // reset with flits buffered; err still set from the overflow above
    for (int i = 0; i < 3; i++) cyc(1'b1, DATASIZE'($urandom), 1'b0);
    do_reset();
    #1;
    check("mrst_valid", 32'(valid_out), 32'd0);
    check("mrst_err",   32'(err_overflow), 32'd0);
    check("mrst_label", 32'(label), 32'd0);
    last = {26'h155, 4'hA};
    cyc(1'b1, last, 1'b0);
    check("post_rst_head", 32'(data_out), 32'(last));

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 59) == 0);
      cyc(1'($urandom_range(0, 3) != 0), DATASIZE'($urandom), 1'($urandom_range(0, 2) == 0));
    end
    rst_n = 1'b0;

    // 5 accepted writes and refused attempts while full
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, DATASIZE'($urandom), 1'b0);
    cyc(1'b1, DATASIZE'($urandom), 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, DATASIZE'($urandom), 1'b0);
`ifdef IPB_STATS_EN
    check("stats_count", 32'(flit_count), 32'd5);
`endif
    check("stats_full", 32'(full), 32'd1);
    cyc(1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
